// File: rtl/zad1_f.sv
// One fixed 4-input Boolean function evaluated three ways (SOP gates, vector index, case),
// plus a registered copy and a sticky cross-check flag. Optional self-test sweep: ZAD1_SELFTEST_EN.
module zad1_f #(
  parameter logic [15:0] TRUTH = 16'hD29A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       f1,
  output logic       f2,
  output logic       f3,
  output logic [2:0] f_q,
  output logic       mismatch,
  output logic       selftest_done
);

  logic [3:0]  code;
  logic [15:0] live_terms;
  logic        live_bad;
  logic        st_bad;

  assign code = {a, b, c, d};

  function automatic logic case_eval(input logic [3:0] x);
    logic r;
    case (x)
      4'h0:    r = TRUTH[0];
      4'h1:    r = TRUTH[1];
      4'h2:    r = TRUTH[2];
      4'h3:    r = TRUTH[3];
      4'h4:    r = TRUTH[4];
      4'h5:    r = TRUTH[5];
      4'h6:    r = TRUTH[6];
      4'h7:    r = TRUTH[7];
      4'h8:    r = TRUTH[8];
      4'h9:    r = TRUTH[9];
      4'hA:    r = TRUTH[10];
      4'hB:    r = TRUTH[11];
      4'hC:    r = TRUTH[12];
      4'hD:    r = TRUTH[13];
      4'hE:    r = TRUTH[14];
      4'hF:    r = TRUTH[15];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Each minterm ANDs four literals, complemented where the code bit is 0.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_minterm
      localparam logic [3:0] IDX = 4'(gi);
      assign live_terms[gi] = TRUTH[gi]
                            & (IDX[3] ? a : ~a)
                            & (IDX[2] ? b : ~b)
                            & (IDX[1] ? c : ~c)
                            & (IDX[0] ? d : ~d);
    end
  endgenerate

  assign f1 = |live_terms;
  assign f2 = TRUTH[code];
  assign f3 = case_eval(code);

  assign live_bad = !((f1 == f2) && (f2 == f3));

`ifdef ZAD1_SELFTEST_EN
  logic [3:0]  cnt_reg;
  logic        done_reg;
  logic [15:0] st_terms;
  logic        st_f1;
  logic        st_f2;
  logic        st_f3;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_st_minterm
      localparam logic [3:0] IDX = 4'(gi);
      assign st_terms[gi] = TRUTH[gi]
                          & (IDX[3] ? cnt_reg[3] : ~cnt_reg[3])
                          & (IDX[2] ? cnt_reg[2] : ~cnt_reg[2])
                          & (IDX[1] ? cnt_reg[1] : ~cnt_reg[1])
                          & (IDX[0] ? cnt_reg[0] : ~cnt_reg[0]);
    end
  endgenerate

  assign st_f1  = |st_terms;
  assign st_f2  = TRUTH[cnt_reg];
  assign st_f3  = case_eval(cnt_reg);
  assign st_bad = (st_f1 != TRUTH[cnt_reg]) || (st_f2 != TRUTH[cnt_reg]) ||
                  (st_f3 != TRUTH[cnt_reg]);

  // Counter parks at 15; the edge that checks code 15 completes the sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= 4'd0;
      done_reg <= 1'b0;
    end else if (cnt_reg == 4'd15) begin
      done_reg <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign selftest_done = done_reg;
`else
  assign st_bad        = 1'b0;
  assign selftest_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q      <= 3'b000;
      mismatch <= 1'b0;
    end else begin
      f_q <= {f1, f2, f3};
      if (live_bad || st_bad)
        mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zad1_f.sv
// Self-checking bench for zad1_f: reference model is a plain minterm list, stimulus partly random.
module tb_zad1_f;

  logic       clk;
  logic       reset;
  logic       a, b, c, d;
  logic       f1, f2, f3;
  logic [2:0] f_q;
  logic       mismatch;
  logic       selftest_done;
  logic       o1, o2, o3;
  logic [2:0] o_q;
  logic       o_mismatch;
  logic       o_done;

  int n_checks = 0;
  int n_fail   = 0;

  zad1_f dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .f1(f1), .f2(f2), .f3(f3), .f_q(f_q),
    .mismatch(mismatch), .selftest_done(selftest_done)
  );

  zad1_f #(.TRUTH(16'h0001)) dut_ovr (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .f1(o1), .f2(o2), .f3(o3), .f_q(o_q),
    .mismatch(o_mismatch), .selftest_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_f(input int code);
    int ones[8] = '{1, 3, 4, 7, 9, 12, 14, 15};
    foreach (ones[k])
      if (ones[k] == code) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_code(input int code);
    {a, b, c, d} = 4'(code);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_code(0);
    #3;
    n_checks++;
    if ({f_q, mismatch, selftest_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: f_q=%b mismatch=%b done=%b, want 000 0 0", f_q, mismatch, selftest_done);
    end
    $display("reset_state: f_q=%b mismatch=%b done=%b", f_q, mismatch, selftest_done);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sweep();
    logic [2:0] want;
    for (int i = 0; i < 16; i++) begin
      set_code(i);
      #10;
      want = {3{ref_f(i)}};
      n_checks++;
      if ({f1, f2, f3} !== want) begin
        n_fail++;
        $display("FAIL sweep code=%0d: f1f2f3=%b, want %b", i, {f1, f2, f3}, want);
      end
      $display("sweep code=%0d f1f2f3=%b", i, {f1, f2, f3});
    end
  endtask

  task automatic test_spot();
    int codes[4] = '{0, 4, 15, 2};
    logic [2:0] want;
    foreach (codes[k]) begin
      set_code(codes[k]);
      #1;
      want = (codes[k] == 4 || codes[k] == 15) ? 3'b111 : 3'b000;
      n_checks++;
      if ({f1, f2, f3} !== want) begin
        n_fail++;
        $display("FAIL spot code=%0d: f1f2f3=%b, want %b", codes[k], {f1, f2, f3}, want);
      end
      $display("spot code=%0d f1f2f3=%b", codes[k], {f1, f2, f3});
    end
  endtask

  task automatic test_registered();
    logic [2:0] want;
    int code;
    @(negedge clk);
    set_code(4);
    @(posedge clk); #1;
    n_checks++;
    if (f_q !== 3'b111) begin
      n_fail++;
      $display("FAIL reg_code4: f_q=%b, want 111", f_q);
    end
    $display("reg_code4 f_q=%b", f_q);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      code = (i < 16) ? i : int'($urandom_range(0, 15));
      set_code(code);
      want = {3{ref_f(code)}};
      @(posedge clk); #1;
      n_checks++;
      if (f_q !== want) begin
        n_fail++;
        $display("FAIL reg_path code=%0d: f_q=%b, want %b", code, f_q, want);
      end
      $display("reg_path code=%0d f_q=%b", code, f_q);
    end
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_after_sweep: mismatch=%b, want 0", mismatch);
    end
    $display("mismatch_after_sweep mismatch=%b", mismatch);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_code(4);
    @(posedge clk); #1;
    n_checks++;
    if (f_q !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset: f_q=%b, want 111", f_q);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({f_q, mismatch} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: f_q=%b mismatch=%b, want 000 0", f_q, mismatch);
    end
    $display("async_reset f_q=%b mismatch=%b", f_q, mismatch);
    #2;
    reset = 1'b0;
    set_code(1);
    @(posedge clk); #1;
    n_checks++;
    if (f_q !== 3'b111) begin
      n_fail++;
      $display("FAIL post_reset_code1: f_q=%b, want 111", f_q);
    end
    $display("post_reset_code1 f_q=%b", f_q);
  endtask

  task automatic test_override();
    logic [2:0] want;
    for (int i = 0; i < 16; i++) begin
      set_code(i);
      #1;
      want = (i == 0) ? 3'b111 : 3'b000;
      n_checks++;
      if ({o1, o2, o3} !== want) begin
        n_fail++;
        $display("FAIL override code=%0d: f1f2f3=%b, want %b", i, {o1, o2, o3}, want);
      end
      $display("override code=%0d f1f2f3=%b", i, {o1, o2, o3});
    end
  endtask

  task automatic test_selftest();
    logic want_done;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (selftest_done !== 1'b0) begin
      n_fail++;
      $display("FAIL selftest_reset: done=%b, want 0", selftest_done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      set_code(int'($urandom_range(0, 15)));
      @(posedge clk); #1;
`ifdef ZAD1_SELFTEST_EN
      want_done = (e >= 16);
`else
      want_done = 1'b0;
`endif
      if (e == 15 || e == 16 || e == 18) begin
        n_checks++;
        if (selftest_done !== want_done) begin
          n_fail++;
          $display("FAIL selftest_edge%0d: done=%b, want %b", e, selftest_done, want_done);
        end
        $display("selftest edge=%0d done=%b", e, selftest_done);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({mismatch, o_mismatch} !== 2'b00) begin
      n_fail++;
      $display("FAIL selftest_mismatch: mismatch=%b ovr_mismatch=%b, want 0 0", mismatch, o_mismatch);
    end
    $display("selftest mismatch=%b ovr_mismatch=%b ovr_done=%b", mismatch, o_mismatch, o_done);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_spot();
    test_registered();
    test_async_reset();
    test_override();
    test_selftest();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
